lsnn_step_sequencer: RTL

- Timestep scheduler for the LSNN core: on each timestep tick, walks neuron indices 0..NUM_NEURONS-1 through the single shared neuron-update unit using a request/response handshake.
- Collects one spike bit per neuron and publishes the spike vector, spike count and a done pulse.
- Queues one early tick, flags overruns, and watchdogs a stalled update unit.

---
 rtl/lsnn_step_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/lsnn_step_sequencer.sv
// Timestep scheduler for the LSNN core: on each tick it walks every neuron index through
// the shared update unit, then publishes the spike vector, its popcount and a step counter.
module lsnn_step_sequencer #(
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = 3,
  parameter int CNT_W       = 4,
  parameter int STEP_W      = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  input  logic                   tick_i,
  output logic                   req_valid_o,
  output logic [IDX_W-1:0]       req_idx_o,
  input  logic                   req_ready_i,
  input  logic                   rsp_valid_i,
  input  logic                   rsp_spike_i,
  output logic [NUM_NEURONS-1:0] spikes_o,
  output logic [CNT_W-1:0]       spike_count_o,
  output logic                   step_done_o,
  output logic [STEP_W-1:0]      step_cnt_o,
  output logic                   busy_o,
  output logic                   overrun_o,
  output logic                   timeout_o,
  input  logic                   err_clr_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_NEURONS - 1);
  localparam logic [7:0]       WDOG_LAST = 8'(TIMEOUT - 1);

  state_t                 state, state_n;
  logic [IDX_W-1:0]       idx, idx_n;
  logic [NUM_NEURONS-1:0] shadow, shadow_n;
  logic                   pending, pending_n;
  logic [7:0]             wdog, wdog_n;
  logic [NUM_NEURONS-1:0] spikes_n;
  logic [CNT_W-1:0]       count_n;
  logic [STEP_W-1:0]      step_n;
  logic                   overrun_n, timeout_n;
  logic                   overrun_set, timeout_set;
  logic                   tick_ok;
  logic                   resolve;
  logic                   spike_bit;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_NEURONS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  assign req_valid_o = (state == ISSUE);
  assign req_idx_o   = idx;
  assign step_done_o = (state == DONE);
  assign busy_o      = (state != IDLE);
  assign tick_ok     = tick_i & enable_i;

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    shadow_n    = shadow;
    pending_n   = pending;
    wdog_n      = wdog;
    spikes_n    = spikes_o;
    count_n     = spike_count_o;
    step_n      = step_cnt_o;
    overrun_set = 1'b0;
    timeout_set = 1'b0;
    resolve     = 1'b0;
    spike_bit   = 1'b0;

    unique case (state)
      IDLE: begin
        if (tick_ok) begin
          state_n  = ISSUE;
          idx_n    = '0;
          shadow_n = '0;
        end
      end
      ISSUE: begin
        if (req_ready_i) begin
          state_n = WAIT;
          wdog_n  = '0;
        end
      end
      WAIT: begin
        // A response on the final watchdog cycle takes priority over the timeout.
        if (rsp_valid_i) begin
          resolve   = 1'b1;
          spike_bit = rsp_spike_i;
        end else if (wdog == WDOG_LAST) begin
          resolve     = 1'b1;
          timeout_set = 1'b1;
        end else begin
          wdog_n = wdog + 8'd1;
        end
      end
      DONE: begin
        pending_n = 1'b0;
        if (pending || tick_ok) begin
          state_n  = ISSUE;
          idx_n    = '0;
          shadow_n = '0;
        end else begin
          state_n = IDLE;
        end
      end
    endcase

    if (resolve) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (idx == IDX_W'(i)) shadow_n[i] = spike_bit;
      end
      if (idx == LAST_IDX) begin
        state_n  = DONE;
        spikes_n = shadow_n;
        count_n  = popcount(shadow_n);
        step_n   = step_cnt_o + STEP_W'(1);
      end else begin
        state_n = ISSUE;
        idx_n   = idx + IDX_W'(1);
      end
    end

    // One tick may wait behind the running step; a tick in DONE with nothing queued
    // is consumed directly by the restart above.
    if (tick_ok && (state != IDLE)) begin
      if (pending) begin
        overrun_set = 1'b1;
      end else if (state != DONE) begin
        pending_n = 1'b1;
      end
    end

    overrun_n = overrun_set | (overrun_o & ~err_clr_i);
    timeout_n = timeout_set | (timeout_o & ~err_clr_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      shadow        <= '0;
      pending       <= 1'b0;
      wdog          <= '0;
      spikes_o      <= '0;
      spike_count_o <= '0;
      step_cnt_o    <= '0;
      overrun_o     <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      shadow        <= shadow_n;
      pending       <= pending_n;
      wdog          <= wdog_n;
      spikes_o      <= spikes_n;
      spike_count_o <= count_n;
      step_cnt_o    <= step_n;
      overrun_o     <= overrun_n;
      timeout_o     <= timeout_n;
    end
  end

endmodule
